chacha_block_ctrl: RTL and testbench

Sequencer for the four-column ChaCha quarter-round array. It owns every array control strobe, step code and address, and loads key, counter and nonce from a host byte port. On start it runs the full double-round schedule, including the column/diagonal rotations over the shift ring, then adds the initial state back in. It then streams the 64-byte keystream block out over a valid/ready port and increments the block counter.

---
 rtl/chacha_pkg.sv | 25 ++
 rtl/chacha_shift_sched.sv | 47 ++++
 rtl/chacha_block_ctrl.sv | 163 ++++++++++++++++
 tb/tb_chacha_block_ctrl.sv | 479 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chacha_pkg.sv
// Shared types and constants for the ChaCha block sequencer.
package chacha_pkg;

    typedef enum logic [3:0] {
        IDLE,
        CLEAR,
        COL_CALC,
        DIAG_SHIFT,
        DIAG_CALC,
        UNDIAG_SHIFT,
        ADD_BACK,
        STREAM,
        INC_CTR
    } state_t;

    localparam int CALC_CYCLES  = 4;
    localparam int SHIFT_CYCLES = 6;
    localparam int BLOCK_BYTES  = 64;

    localparam logic [1:0] STEP_0 = 2'd0;
    localparam logic [1:0] STEP_1 = 2'd1;
    localparam logic [1:0] STEP_2 = 2'd2;
    localparam logic [1:0] STEP_3 = 2'd3;

endpackage

// File: rtl/chacha_shift_sched.sv
// Step sequence for the shift-ring phases: diagonalise rotates b,c,d by 1,2,3;
// undiagonalise brings them back with the complementary rotation counts.
module chacha_shift_sched
    import chacha_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       undiag,
    output logic [1:0] step,
    output logic       last
);

    logic [2:0] phase;

    assign last = run && (phase == 3'(SHIFT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase <= '0;
        end else if (run && !last) begin
            phase <= phase + 3'd1;
        end else begin
            phase <= '0;
        end
    end

    always_comb begin
        step = STEP_0;
        if (run) begin
            if (undiag) begin
                case (phase)
                    3'd0, 3'd1, 3'd2: step = STEP_1;
                    3'd3, 3'd4:       step = STEP_2;
                    default:          step = STEP_3;
                endcase
            end else begin
                case (phase)
                    3'd0:       step = STEP_1;
                    3'd1, 3'd2: step = STEP_2;
                    default:    step = STEP_3;
                endcase
            end
        end
    end

endmodule

// File: rtl/chacha_block_ctrl.sv
// Sequencer for the four-column ChaCha quarter-round array: host load,
// double-round schedule, add-back, keystream streaming and counter increment.
module chacha_block_ctrl
    import chacha_pkg::*;
#(
    parameter int DOUBLE_ROUNDS = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       busy,
    output logic       done,
    input  logic       wr_en,
    input  logic [5:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       wr_ready,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic       q_write,
    output logic       q_calc,
    output logic       q_shift,
    output logic       q_add_back,
    output logic       q_clear,
    output logic       q_inc_ctr,
    output logic [1:0] q_step,
    output logic [5:0] q_addr,
    output logic [7:0] q_data_in,
    input  logic [7:0] q_data_out
);

    state_t     state;
    logic [1:0] calc_ph;
    logic [3:0] dr_cnt;
    logic [5:0] byte_idx;
    logic       in_calc;
    logic       in_shift;
    logic       shift_last;
    logic [1:0] shift_step;

    assign in_calc  = (state == COL_CALC) || (state == DIAG_CALC);
    assign in_shift = (state == DIAG_SHIFT) || (state == UNDIAG_SHIFT);

    chacha_shift_sched u_shift (
        .clk    (clk),
        .rst_n  (rst_n),
        .run    (in_shift),
        .undiag (state == UNDIAG_SHIFT),
        .step   (shift_step),
        .last   (shift_last)
    );

    assign busy      = (state != IDLE);
    assign wr_ready  = (state == IDLE);
    assign q_write   = wr_ready && wr_en;
    assign q_data_in = wr_data;
    assign out_data  = q_data_out;
    assign out_last  = out_valid && (byte_idx == 6'(BLOCK_BYTES - 1));
    assign q_step    = in_calc ? calc_ph : (in_shift ? shift_step : STEP_0);

    // The host owns the address in IDLE; the streamer owns it in STREAM.
    always_comb begin
        q_addr = '0;
        if (state == IDLE) begin
            q_addr = wr_addr;
        end else if (state == STREAM) begin
            q_addr = byte_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            calc_ph    <= '0;
            dr_cnt     <= '0;
            byte_idx   <= '0;
            q_calc     <= 1'b0;
            q_shift    <= 1'b0;
            q_add_back <= 1'b0;
            q_clear    <= 1'b0;
            q_inc_ctr  <= 1'b0;
            out_valid  <= 1'b0;
            done       <= 1'b0;
        end else begin
            q_calc     <= 1'b0;
            q_shift    <= 1'b0;
            q_add_back <= 1'b0;
            q_clear    <= 1'b0;
            q_inc_ctr  <= 1'b0;
            done       <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= CLEAR;
                        q_clear <= 1'b1;
                        dr_cnt  <= '0;
                        calc_ph <= '0;
                    end
                end
                CLEAR: begin
                    state  <= COL_CALC;
                    q_calc <= 1'b1;
                end
                COL_CALC, DIAG_CALC: begin
                    calc_ph <= calc_ph + 2'd1;
                    if (calc_ph == 2'(CALC_CYCLES - 1)) begin
                        state   <= (state == COL_CALC) ? DIAG_SHIFT : UNDIAG_SHIFT;
                        q_shift <= 1'b1;
                    end else begin
                        q_calc <= 1'b1;
                    end
                end
                DIAG_SHIFT: begin
                    if (shift_last) begin
                        state  <= DIAG_CALC;
                        q_calc <= 1'b1;
                    end else begin
                        q_shift <= 1'b1;
                    end
                end
                UNDIAG_SHIFT: begin
                    if (shift_last) begin
                        dr_cnt <= dr_cnt + 4'd1;
                        if (dr_cnt + 4'd1 == 4'(DOUBLE_ROUNDS)) begin
                            state      <= ADD_BACK;
                            q_add_back <= 1'b1;
                        end else begin
                            state  <= COL_CALC;
                            q_calc <= 1'b1;
                        end
                    end else begin
                        q_shift <= 1'b1;
                    end
                end
                ADD_BACK: begin
                    state     <= STREAM;
                    out_valid <= 1'b1;
                    byte_idx  <= '0;
                end
                STREAM: begin
                    if (out_ready) begin
                        if (byte_idx == 6'(BLOCK_BYTES - 1)) begin
                            state     <= INC_CTR;
                            out_valid <= 1'b0;
                            q_inc_ctr <= 1'b1;
                            done      <= 1'b1;
                        end else begin
                            byte_idx <= byte_idx + 6'd1;
                        end
                    end
                end
                INC_CTR: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chacha_block_ctrl.sv
// Bench for chacha_block_ctrl: a behavioural ChaCha array model answers the
// controller's strobes, and per-scenario tasks compare against a host-side reference.
module tb_chacha_block_ctrl;

    localparam int DR = 10;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       busy;
    logic       done;
    logic       wr_en;
    logic [5:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic       q_write;
    logic       q_calc;
    logic       q_shift;
    logic       q_add_back;
    logic       q_clear;
    logic       q_inc_ctr;
    logic [1:0] q_step;
    logic [5:0] q_addr;
    logic [7:0] q_data_in;
    logic [7:0] q_data_out;

    int total;
    int bad;

    chacha_block_ctrl #(.DOUBLE_ROUNDS(DR)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .q_write    (q_write),
        .q_calc     (q_calc),
        .q_shift    (q_shift),
        .q_add_back (q_add_back),
        .q_clear    (q_clear),
        .q_inc_ctr  (q_inc_ctr),
        .q_step     (q_step),
        .q_addr     (q_addr),
        .q_data_in  (q_data_in),
        .q_data_out (q_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference ChaCha ----------------
    function automatic logic [127:0] qr(input logic [31:0] a0, b0, c0, d0);
        logic [31:0] a, b, c, d;
        a = a0; b = b0; c = c0; d = d0;
        a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
        c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
        a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
        c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
        return {a, b, c, d};
    endfunction

    function automatic logic [511:0] chacha(input logic [511:0] s, input int dr);
        logic [31:0]  x [16];
        logic [511:0] o;
        for (int i = 0; i < 16; i++) x[i] = s[32*i +: 32];
        for (int r = 0; r < dr; r++) begin
            {x[0], x[4], x[8],  x[12]} = qr(x[0], x[4], x[8],  x[12]);
            {x[1], x[5], x[9],  x[13]} = qr(x[1], x[5], x[9],  x[13]);
            {x[2], x[6], x[10], x[14]} = qr(x[2], x[6], x[10], x[14]);
            {x[3], x[7], x[11], x[15]} = qr(x[3], x[7], x[11], x[15]);
            {x[0], x[5], x[10], x[15]} = qr(x[0], x[5], x[10], x[15]);
            {x[1], x[6], x[11], x[12]} = qr(x[1], x[6], x[11], x[12]);
            {x[2], x[7], x[8],  x[13]} = qr(x[2], x[7], x[8],  x[13]);
            {x[3], x[4], x[9],  x[14]} = qr(x[3], x[4], x[9],  x[14]);
        end
        for (int i = 0; i < 16; i++) o[32*i +: 32] = x[i] + s[32*i +: 32];
        return o;
    endfunction

    localparam logic [127:0] SIGMA = {32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};

    // ---------------- array model driven by the DUT strobes ----------------
    logic [511:0] st = {384'd0, SIGMA};
    logic [511:0] init_s = '0;
    logic [511:0] ks = '0;
    int           trace[$];
    bit           tracing = 1'b0;
    int           excl_viol = 0;
    int           inc_count = 0;

    assign q_data_out = ks[8*int'(q_addr) +: 8];

    always @(posedge clk) begin
        int n;
        int code;
        n = int'(q_write) + int'(q_calc) + int'(q_shift) + int'(q_add_back)
          + int'(q_clear) + int'(q_inc_ctr);
        if (n > 1) excl_viol <= excl_viol + 1;
        code = q_clear ? 4 : q_calc ? 8 : q_shift ? 12 : q_add_back ? 16
             : q_write ? 20 : q_inc_ctr ? 24 : 0;
        code = code + int'(q_step);
        if (q_write && q_addr[5:4] != 2'd0) st[8*int'(q_addr) +: 8] <= q_data_in;
        if (q_clear) begin
            init_s <= st;
            trace.delete();
            trace.push_back(code);
            tracing <= 1'b1;
        end else if (tracing) begin
            trace.push_back(code);
        end
        if (q_add_back) begin
            ks      <= chacha(init_s, DR);
            tracing <= 1'b0;
        end
        if (q_inc_ctr) begin
            {st[447:416], st[415:384]} <= {st[447:416], st[415:384]} + 64'd1;
            inc_count <= inc_count + 1;
        end
    end

    // ---------------- host-side reference and stimulus helpers ----------------
    logic [511:0] host_blk = {384'd0, SIGMA};

    function automatic logic [383:0] rfc_rows();
        logic [383:0] r;
        r = '0;
        for (int k = 0; k < 32; k++) r[8*k +: 8] = 8'(k);
        r[256 +: 32] = 32'h00000001;
        r[288 +: 32] = 32'h09000000;
        r[320 +: 32] = 32'h4a000000;
        r[352 +: 32] = 32'h00000000;
        return r;
    endfunction

    task automatic bump_host_ctr();
        {host_blk[447:416], host_blk[415:384]} = {host_blk[447:416], host_blk[415:384]} + 64'd1;
    endtask

    task automatic load_rows(input logic [383:0] rows, input bit skip_last);
        for (int k = 0; k < 48; k++) begin
            if (!(skip_last && k == 47)) begin
                wr_en   = 1'b1;
                wr_addr = 6'(16 + k);
                wr_data = rows[8*k +: 8];
                @(posedge clk); #1;
            end
        end
        wr_en = 1'b0;
        host_blk[511:128] = rows;
    endtask

    task automatic start_block(input bit with_write, input logic [7:0] d);
        @(posedge clk); #1;
        start = 1'b1;
        if (with_write) begin
            wr_en   = 1'b1;
            wr_addr = 6'd63;
            wr_data = d;
        end
        @(posedge clk); #1;
        start = 1'b0;
        wr_en = 1'b0;
    endtask

    // Entered in cycle 1 after start; returns the cycle index of first out_valid.
    task automatic wait_valid(input bit interfere, output int cyc, output int wr_bad);
        cyc = 1;
        wr_bad = 0;
        while (!out_valid && cyc < 2000) begin
            if (interfere) begin
                wr_en   = 1'b1;
                wr_addr = 6'($urandom);
                wr_data = 8'($urandom);
                start   = 1'b1;
                #1;
                if (wr_ready || q_write) wr_bad++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        wr_en = 1'b0;
        start = 1'b0;
    endtask

    task automatic collect(input bit rnd, input int stop_at, output logic [511:0] got,
                           output int hs, output int hold_err, output int last_err,
                           output bit got_done);
        bit         prev_stall;
        logic [5:0] prev_addr;
        int         ncyc;
        got = '0; hs = 0; hold_err = 0; last_err = 0; got_done = 1'b0;
        prev_stall = 1'b0; prev_addr = '0; ncyc = 0;
        while (ncyc < 5000) begin
            out_ready = rnd ? 1'($urandom) : 1'b1;
            #1;
            if (prev_stall && q_addr !== prev_addr) hold_err++;
            if (out_valid) begin
                if (q_addr !== 6'(hs)) hold_err++;
                if (out_last !== (hs == 63)) last_err++;
                if (out_ready) begin
                    if (hs < 64) got[8*hs +: 8] = out_data;
                    hs++;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_addr  = q_addr;
            @(posedge clk); #1;
            ncyc++;
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (hs >= stop_at) break;
        end
        out_ready = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({busy, out_valid, done, q_write, q_calc, q_shift, q_add_back, q_clear, q_inc_ctr, q_step} !== 11'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %b want 0",
                {busy, out_valid, done, q_write, q_calc, q_shift, q_add_back, q_clear, q_inc_ctr, q_step});
        end
        total++;
        if (wr_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_wr_ready: got %b want 1", wr_ready);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_rfc_vector();
        logic [511:0] exp, got;
        int cyc, wr_bad, hs, hold_err, last_err;
        bit got_done;
        int exp_q[$];
        int errs;
        int dsteps[6] = '{1, 2, 2, 3, 3, 3};
        int usteps[6] = '{1, 1, 1, 2, 2, 3};

        load_rows(rfc_rows(), 1'b0);
        exp = chacha(host_blk, DR);
        start_block(1'b0, 8'd0);
        total++;
        if (q_clear !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL clear_cycle1: got clear=%b busy=%b want 1 1", q_clear, busy);
        end
        wait_valid(1'b1, cyc, wr_bad);
        total++;
        if (cyc !== 3 + 20*DR) begin
            bad++;
            $display("FAIL first_valid_latency: got %0d want %0d", cyc, 3 + 20*DR);
        end
        total++;
        if (wr_bad !== 0) begin
            bad++;
            $display("FAIL busy_write_block: got %0d leaked cycles want 0", wr_bad);
        end

        exp_q.push_back(4);
        for (int r = 0; r < DR; r++) begin
            for (int s = 0; s < 4; s++) exp_q.push_back(8 + s);
            for (int s = 0; s < 6; s++) exp_q.push_back(12 + dsteps[s]);
            for (int s = 0; s < 4; s++) exp_q.push_back(8 + s);
            for (int s = 0; s < 6; s++) exp_q.push_back(12 + usteps[s]);
        end
        exp_q.push_back(16);
        errs = 0;
        if (trace.size() != exp_q.size()) errs = 1000;
        else foreach (exp_q[i]) if (trace[i] != exp_q[i]) errs++;
        total++;
        if (errs !== 0) begin
            bad++;
            $display("FAIL strobe_trace: got len=%0d errs=%0d want len=%0d errs=0",
                trace.size(), errs, exp_q.size());
        end

        collect(1'b0, 64, got, hs, hold_err, last_err, got_done);
        total++;
        if (got[63:0] !== 64'h15593bd1e4e7f110) begin
            bad++;
            $display("FAIL rfc_first_bytes: got %h want 15593bd1e4e7f110", got[63:0]);
        end
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL rfc_block: got %h want %h", got, exp);
        end
        total++;
        if (hs !== 64 || got_done !== 1'b1) begin
            bad++;
            $display("FAIL rfc_handshakes: got hs=%0d done=%b want 64 1", hs, got_done);
        end
        total++;
        if (hold_err !== 0 || last_err !== 0) begin
            bad++;
            $display("FAIL rfc_addr_last: got addr_err=%0d last_err=%0d want 0 0", hold_err, last_err);
        end
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b0 || wr_ready !== 1'b1) begin
            bad++;
            $display("FAIL no_queued_start: got busy=%b wr_ready=%b want 0 1", busy, wr_ready);
        end
        bump_host_ctr();
    endtask

    task automatic test_back_to_back();
        logic [511:0] exp, got;
        int cyc, wr_bad, hs, hold_err, last_err, inc_before;
        bit got_done;
        inc_before = inc_count;
        exp = chacha(host_blk, DR);
        start_block(1'b0, 8'd0);
        wait_valid(1'b0, cyc, wr_bad);
        collect(1'b0, 64, got, hs, hold_err, last_err, got_done);
        @(posedge clk); #1;
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL counter2_block: got %h want %h", got, exp);
        end
        total++;
        if (inc_count - inc_before !== 1) begin
            bad++;
            $display("FAIL inc_ctr_pulses: got %0d want 1", inc_count - inc_before);
        end
        bump_host_ctr();
    endtask

    task automatic test_backpressure();
        logic [511:0] exp, got;
        int cyc, wr_bad, hs, hold_err, last_err;
        bit got_done;
        exp = chacha(host_blk, DR);
        start_block(1'b0, 8'd0);
        wait_valid(1'b0, cyc, wr_bad);
        collect(1'b1, 64, got, hs, hold_err, last_err, got_done);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL stall_block: got %h want %h", got, exp);
        end
        total++;
        if (hs !== 64 || got_done !== 1'b1) begin
            bad++;
            $display("FAIL stall_handshakes: got hs=%0d done=%b want 64 1", hs, got_done);
        end
        total++;
        if (hold_err !== 0 || last_err !== 0) begin
            bad++;
            $display("FAIL stall_addr_hold: got addr_err=%0d last_err=%0d want 0 0", hold_err, last_err);
        end
        bump_host_ctr();
    endtask

    task automatic test_reset_mid_stream();
        logic [511:0] exp, got;
        int cyc, wr_bad, hs, hold_err, last_err;
        bit got_done;
        start_block(1'b0, 8'd0);
        wait_valid(1'b0, cyc, wr_bad);
        collect(1'b0, 17, got, hs, hold_err, last_err, got_done);
        total++;
        if (hs !== 17 || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL partial_stream: got hs=%0d valid=%b want 17 1", hs, out_valid);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        total++;
        if ({busy, out_valid, done, q_write, q_calc, q_shift, q_add_back, q_clear, q_inc_ctr, q_step} !== 11'd0) begin
            bad++;
            $display("FAIL abort_outputs: got %b want 0",
                {busy, out_valid, done, q_write, q_calc, q_shift, q_add_back, q_clear, q_inc_ctr, q_step});
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        load_rows(rfc_rows(), 1'b0);
        exp = chacha(host_blk, DR);
        start_block(1'b0, 8'd0);
        wait_valid(1'b0, cyc, wr_bad);
        collect(1'b0, 64, got, hs, hold_err, last_err, got_done);
        total++;
        if (got !== exp || got[63:0] !== 64'h15593bd1e4e7f110) begin
            bad++;
            $display("FAIL reload_block: got %h want %h", got, exp);
        end
        bump_host_ctr();
    endtask

    task automatic test_counter_carry();
        logic [383:0] rows;
        logic [511:0] exp, got;
        logic [31:0]  hi;
        int cyc, wr_bad, hs, hold_err, last_err;
        bit got_done;
        for (int k = 0; k < 12; k++) rows[32*k +: 32] = $urandom;
        hi = $urandom;
        rows[256 +: 32] = 32'hffffffff;
        rows[288 +: 32] = hi;
        @(posedge clk); #1;
        load_rows(rows, 1'b1);
        exp = chacha(host_blk, DR);
        start_block(1'b1, rows[383:376]);
        wait_valid(1'b0, cyc, wr_bad);
        collect(1'b0, 64, got, hs, hold_err, last_err, got_done);
        @(posedge clk); #1;
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL carry_block1: got %h want %h", got, exp);
        end
        total++;
        if (st[415:384] !== 32'h0 || st[447:416] !== hi + 32'd1) begin
            bad++;
            $display("FAIL carry_words: got %h_%h want %h_00000000", st[447:416], st[415:384], hi + 32'd1);
        end
        bump_host_ctr();
        exp = chacha(host_blk, DR);
        start_block(1'b0, 8'd0);
        wait_valid(1'b0, cyc, wr_bad);
        collect(1'b0, 64, got, hs, hold_err, last_err, got_done);
        @(posedge clk); #1;
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL carry_block2: got %h want %h", got, exp);
        end
    endtask

    task automatic test_strobe_exclusion();
        total++;
        if (excl_viol !== 0) begin
            bad++;
            $display("FAIL strobe_exclusion: got %0d overlapping cycles want 0", excl_viol);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst_n = 1'b0;
        start = 1'b0;
        wr_en = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        out_ready = 1'b1;
        test_reset();
        test_rfc_vector();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_stream();
        test_counter_carry();
        test_strobe_exclusion();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
